image_loader: RTL and testbench

//  Upstream feeder for the processor's external data memory write port (wren/wraddress/data).

---
 rtl/image_loader.sv | 123 ++++++++++++
 tb/tb_image_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_loader.sv
// Packs an 8-bit valid/ready byte stream into little-endian 32-bit words and
// writes them to consecutive word addresses of the data memory write port.
module image_loader #(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned NUM_WORDS = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddress,
    output logic [31:0]       data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_count
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NUM_WORDS - 1);

    // S_LAST is the wren cycle of the final word: still busy, no longer accepting bytes.
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_LAST,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       data_q, data_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] wraddress_q, wraddress_d;
    logic [ADDR_W-1:0] word_count_q, word_count_d;
    logic              transfer;

    assign byte_ready = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD) || (state_q == S_LAST);
    assign done       = (state_q == S_DONE);
    assign wren       = wren_q;
    assign wraddress  = wraddress_q;
    assign data       = data_q;
    assign word_count = word_count_q;
    assign transfer   = byte_valid & byte_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            lane_q       <= 2'd0;
            asm_q        <= '0;
            data_q       <= '0;
            wren_q       <= 1'b0;
            wraddress_q  <= BASE;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            data_q       <= data_d;
            wren_q       <= wren_d;
            wraddress_q  <= wraddress_d;
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        asm_d        = asm_q;
        data_d       = data_q;
        wren_d       = 1'b0;
        wraddress_d  = wraddress_q;
        // The count follows the wren cycle, so it reads as words actually written.
        word_count_d = wren_q ? word_count_q + ADDR_W'(1) : word_count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    lane_d       = 2'd0;
                    word_count_d = '0;
                end
            end
            S_LOAD: begin
                if (transfer) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0:    asm_d[7:0]   = byte_data;
                        2'd1:    asm_d[15:8]  = byte_data;
                        2'd2:    asm_d[23:16] = byte_data;
                        default: begin
                            data_d      = {byte_data, asm_q};
                            wren_d      = 1'b1;
                            wraddress_d = BASE + word_count_q;
                            if (word_count_q == LAST_CNT) begin
                                state_d = S_LAST;
                            end
                        end
                    endcase
                end
            end
            S_LAST:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Abort drops the partial word and any write that would have issued next cycle.
        if (abort) begin
            state_d      = S_IDLE;
            lane_d       = 2'd0;
            wren_d       = 1'b0;
            data_d       = data_q;
            wraddress_d  = wraddress_q;
            word_count_d = word_count_q;
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Directed-sequence bench with random byte data and gaps; writes are checked
// against words rebuilt from the recorded list of accepted bytes.
module tb_image_loader;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned BASE   = 100;
    localparam int unsigned NW     = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              wren;
    logic [ADDR_W-1:0] wraddress;
    logic [31:0]       data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] word_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0]  acc_b[$];
    int          acc_c[$];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    int          wr_c[$];

    image_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .NUM_WORDS(NW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .wren(wren), .wraddress(wraddress), .data(data),
        .busy(busy), .done(done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record handshakes (take effect at the next edge) and visible write strobes.
    always @(negedge clk) begin
        if (reset && byte_valid && byte_ready) begin
            acc_b.push_back(byte_data);
            acc_c.push_back(cyc);
        end
        if (wren === 1'b1) begin
            wr_a.push_back(32'(wraddress));
            wr_d.push_back(data);
            wr_c.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        acc_b.delete(); acc_c.delete();
        wr_a.delete(); wr_d.delete(); wr_c.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        int   guard;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 16) begin
            @(negedge clk);
            acc = byte_ready;
            tick();
            guard++;
        end
        byte_valid = 1'b0;
        chk("byte_accepted", 32'(acc), 32'd1);
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wren"},       32'(wren),       32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_wraddress"},  32'(wraddress),  32'(BASE));
        chk({tag, "_data"},       data,            32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    // Word k = accepted bytes 4k..4k+3 little-endian, at BASE+k, one cycle after byte 4k+3.
    task automatic check_writes(input string tag, input int exp_n);
        chk({tag, "_nwrites"}, 32'(wr_a.size()), 32'(exp_n));
        for (int k = 0; k < exp_n && k < wr_a.size() && 4 * k + 3 < acc_b.size(); k++) begin
            chk({tag, "_addr"}, wr_a[k], 32'(BASE + k));
            chk({tag, "_data"}, wr_d[k],
                {acc_b[4*k+3], acc_b[4*k+2], acc_b[4*k+1], acc_b[4*k]});
            chk({tag, "_latency"}, 32'(wr_c[k]), 32'(acc_c[4*k+3] + 1));
        end
    endtask

    initial begin
        // Reset and idle values
        reset = 1'b0;
        repeat (3) tick();
        chk_rst("reset");
        reset = 1'b1;
        tick();
        chk_rst("idle");

        // Single word, fixed bytes back-to-back
        clr();
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready", 32'(byte_ready), 32'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        chk("t1_wren", 32'(wren), 32'd1);
        chk("t1_wraddress", 32'(wraddress), 32'(BASE));
        chk("t1_data", data, 32'h44332211);
        tick();
        chk("t1_wren_one_cycle", 32'(wren), 32'd0);
        chk("t1_word_count", 32'(word_count), 32'd1);
        check_writes("t1", 1);

        // Abort in LOAD keeps the count; start with abort stays idle
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(byte_ready), 32'd0);
        chk("abort_word_count", 32'(word_count), 32'd1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);

        // Abort after 6 bytes loses the partial word
        clr();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), $urandom_range(0, 2));
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (6) tick();
        check_writes("t4", 1);
        chk("t4_word_count", 32'(word_count), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);

        // Restart reloads from BASE
        clr();
        pulse_start();
        chk("t4r_word_count0", 32'(word_count), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), $urandom_range(0, 2));
        tick();
        check_writes("t4r", 1);
        chk("t4r_word_count", 32'(word_count), 32'd1);

        // Reset with a write strobe out
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        chk("t5_pending_wren", 32'(wren), 32'd1);
        chk("t5_pending_addr", 32'(wraddress), 32'(BASE + 1));
        reset = 1'b0;
        tick();
        chk_rst("t5");
        tick();
        chk_rst("t5_hold");
        reset = 1'b1;
        tick();

        // Full load with random gaps and a start pulse mid-load
        clr();
        pulse_start();
        for (int i = 0; i < 4 * NW; i++) begin
            if (i == 6) begin
                pulse_start();
                chk("t6_wc_after_start", 32'(word_count), 32'd1);
            end
            send_byte(8'($urandom), $urandom_range(0, 3));
        end
        chk("t2_ready_last", 32'(byte_ready), 32'd0);
        chk("t2_wren_last", 32'(wren), 32'd1);
        chk("t2_addr_last", 32'(wraddress), 32'(BASE + NW - 1));
        tick();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_ready", 32'(byte_ready), 32'd0);
        chk("t2_wren", 32'(wren), 32'd0);
        chk("t2_word_count", 32'(word_count), 32'(NW));
        chk("t2_wraddress_hold", 32'(wraddress), 32'(BASE + NW - 1));
        check_writes("t2", NW);

        // Extra bytes offered in DONE are not taken
        byte_valid = 1'b1;
        byte_data  = 8'($urandom);
        repeat (8) tick();
        byte_valid = 1'b0;
        chk("t2_extra_accepted", 32'(acc_b.size()), 32'(4 * NW));
        chk("t2_extra_writes", 32'(wr_a.size()), 32'(NW));
        chk("t2_done_held", 32'(done), 32'd1);

        // Start from DONE, continuous stream
        clr();
        pulse_start();
        chk("t3_done_cleared", 32'(done), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_word_count0", 32'(word_count), 32'd0);
        for (int i = 0; i < 4 * NW; i++) send_byte(8'($urandom), 0);
        tick();
        check_writes("t3", NW);
        if (acc_c.size() == 4 * NW) begin
            chk("t3_no_stall", 32'(acc_c[4*NW-1] - acc_c[0]), 32'(4 * NW - 1));
        end
        for (int k = 0; k + 1 < wr_c.size(); k++) begin
            chk("t3_wren_spacing", 32'(wr_c[k+1] - wr_c[k]), 32'd4);
        end
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_word_count", 32'(word_count), 32'(NW));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
